// File: rtl/reaction_game_pkg.sv
// Shared types and default timing constants for the reaction game input path.
package reaction_game_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_t;

    // Default cycle counts for a 50 MHz board clock
    localparam int unsigned KEY_DEBOUNCE_1MS = 50000;
    localparam int unsigned KEY_HOLD_1S      = 50000000;

endpackage

// File: rtl/reaction_game_key_debounce.sv
// One key: two-flop synchronizer, debounce FSM, registered press/release pulses.
// Optional long-press hold pulse when KEY_COND_HOLD_EN is defined.
module reaction_game_key_debounce
    import reaction_game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_1MS,
    parameter int unsigned HOLD_CYCLES     = KEY_HOLD_1S
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_hold
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_cfg
        $error("reaction_game_key_debounce: need DEBOUNCE_CYCLES >= 1 and HOLD_CYCLES > DEBOUNCE_CYCLES");
    end

    logic          sync1_q, sync2_q;
    logic          pressed_s;
    key_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    assign pressed_s = ~sync2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            RELEASED: begin
                cnt_d = '0;
                if (pressed_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!pressed_s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!pressed_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            RELEASE_WAIT: begin
                if (pressed_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(DEBOUNCE_CYCLES)) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
        // Level is registered from the next state so it lines up with the pulses
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= key_n;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;

`ifdef KEY_COND_HOLD_EN
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          hold_q, hold_d;

    // Counts across release bounces; saturates so the hold fires once per press
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        hold_d     = 1'b0;
        if (state_q == PRESS_WAIT && state_d == PRESSED) begin
            hold_cnt_d = '0;
        end else if ((state_q == PRESSED || state_q == RELEASE_WAIT) &&
                     hold_cnt_q != HW'(HOLD_CYCLES)) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
            hold_d     = (hold_cnt_q == HW'(HOLD_CYCLES - 1));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= '0;
            hold_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            hold_q     <= hold_d;
        end
    end

    assign key_hold = hold_q;
`else
    assign key_hold = 1'b0;
`endif

endmodule

// File: rtl/reaction_game_key_conditioner.sv
// Conditions NUM_KEYS raw active-low pushbuttons into debounced levels and gated events.
// Define KEY_COND_HOLD_EN to enable the long-press key_hold pulses.
module reaction_game_key_conditioner
    import reaction_game_pkg::*;
#(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_1MS,
    parameter int unsigned HOLD_CYCLES     = KEY_HOLD_1S
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic                en,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_hold
);

    logic [NUM_KEYS-1:0] press_raw;
    logic [NUM_KEYS-1:0] release_raw;
    logic [NUM_KEYS-1:0] hold_raw;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            reaction_game_key_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .HOLD_CYCLES    (HOLD_CYCLES)
            ) u_debounce (
                .clk        (clk),
                .reset_n    (reset_n),
                .key_n      (key_n[gi]),
                .key_level  (key_level[gi]),
                .key_press  (press_raw[gi]),
                .key_release(release_raw[gi]),
                .key_hold   (hold_raw[gi])
            );
        end
    endgenerate

    // Events dropped while en is low are lost; level tracking is never gated
    assign key_press   = press_raw   & {NUM_KEYS{en}};
    assign key_release = release_raw & {NUM_KEYS{en}};
    assign key_hold    = hold_raw    & {NUM_KEYS{en}};

endmodule
